operand_issue: RTL and testbench

- Decode/operand-issue stage directly upstream of register_file in the 32-bit RISC pipeline.
- Accepts fetched instructions over a valid/ready handshake and extracts register indices.
- Drives register_file read ports and tracks pending writes in a 32-entry scoreboard; stalls on hazards.
- Registers opcode, destination and both operands into a single-entry ID/EX output buffer for the execute stage.

---
 rtl/operand_issue.sv | 102 ++++++++++
 tb/tb_operand_issue.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/operand_issue.sv
// Decode/operand-issue stage: reads register_file, tracks pending writes, buffers one ID/EX entry.
// One cycle accept-to-out_valid; stalls on RAW/WAW hazard, flush, or a full buffer that execute is not draining.
module operand_issue #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OPC_W  = 6
) (
  input  logic                   clk,
  input  logic                   clear_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_W-1:0]      in_instr,
  output logic [REG_AW-1:0]      rf_read_regA,
  output logic [REG_AW-1:0]      rf_read_regB,
  output logic                   rf_rd,
  input  logic [DATA_W-1:0]      rf_readA,
  input  logic [DATA_W-1:0]      rf_readB,
  input  logic                   wb_valid,
  input  logic [REG_AW-1:0]      wb_reg,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OPC_W-1:0]       out_opcode,
  output logic [REG_AW-1:0]      out_dest,
  output logic                   out_wen,
  output logic [DATA_W-1:0]      out_opA,
  output logic [DATA_W-1:0]      out_opB,
  output logic [(1<<REG_AW)-1:0] busy_mask
);

  localparam int NREG    = 1 << REG_AW;
  localparam int OPC_LSB = DATA_W - OPC_W;
  localparam int RD_LSB  = OPC_LSB - REG_AW;
  localparam int RS1_LSB = RD_LSB - REG_AW;
  localparam int RS2_LSB = RS1_LSB - REG_AW;

  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rd, rs1, rs2;
  logic [15:0]       imm;
  logic [DATA_W-1:0] imm_ext;
  logic              writes_rd, uses_rs2, hazard, accept;
  logic [NREG-1:0]   set_mask, clr_mask;

  assign opcode    = in_instr[OPC_LSB +: OPC_W];
  assign rd        = in_instr[RD_LSB  +: REG_AW];
  assign rs1       = in_instr[RS1_LSB +: REG_AW];
  assign rs2       = in_instr[RS2_LSB +: REG_AW];
  assign imm       = in_instr[15:0];
  assign imm_ext   = {{(DATA_W-16){imm[15]}}, imm};
  assign writes_rd = ~opcode[OPC_W-1];
  assign uses_rs2  = ~opcode[OPC_W-2];

  assign rf_read_regA = rs1;
  assign rf_read_regB = rs2;
  assign rf_rd        = in_valid;

  // Hazard uses the pre-edge scoreboard, so a same-cycle writeback does not unblock.
  assign hazard    = busy_mask[rs1] | (uses_rs2 & busy_mask[rs2]) | (writes_rd & busy_mask[rd]);
  assign out_valid = (state == FULL);
  assign in_ready  = clear_n & ~flush & ~hazard & (~out_valid | out_ready);
  assign accept    = in_valid & in_ready;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (wb_valid)
      clr_mask[wb_reg] = 1'b1;
    if (flush && out_valid && out_wen)
      clr_mask[out_dest] = 1'b1;
    if (accept && writes_rd)
      set_mask[rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state      <= EMPTY;
      busy_mask  <= '0;
      out_opcode <= '0;
      out_dest   <= '0;
      out_wen    <= 1'b0;
      out_opA    <= '0;
      out_opB    <= '0;
    end else begin
      // Set applied after clear so a new claim beats a stale writeback.
      busy_mask <= (busy_mask & ~clr_mask) | set_mask;
      if (accept) begin
        state      <= FULL;
        out_opcode <= opcode;
        out_dest   <= rd;
        out_wen    <= writes_rd;
        out_opA    <= rf_readA;
        out_opB    <= uses_rs2 ? rf_readB : imm_ext;
      end else if (flush || out_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_operand_issue.sv
// Directed vector table for the listed scenarios, then random traffic against a scoreboard/buffer model.
module tb_operand_issue;

  logic        clk = 1'b0;
  logic        clear_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [4:0]  rf_read_regA, rf_read_regB;
  logic        rf_rd;
  logic [31:0] rf_readA, rf_readB;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_opcode;
  logic [4:0]  out_dest;
  logic        out_wen;
  logic [31:0] out_opA, out_opB;
  logic [31:0] busy_mask;

  logic [31:0] rf [32];
  assign rf_readA = rf[rf_read_regA];
  assign rf_readB = rf[rf_read_regB];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_issue dut (
    .clk(clk), .clear_n(clear_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .rf_read_regA(rf_read_regA), .rf_read_regB(rf_read_regB),
    .rf_rd(rf_rd), .rf_readA(rf_readA), .rf_readB(rf_readB),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_dest(out_dest), .out_wen(out_wen), .out_opA(out_opA), .out_opB(out_opB),
    .busy_mask(busy_mask)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        iv;
    logic [5:0]  opc;
    logic [4:0]  rd, rs1;
    logic [15:0] imm;
    logic        wbv;
    logic [4:0]  wbr;
    logic        fl, ordy;
    logic        e_rdy, e_vld;
    logic [4:0]  e_dest;
    logic        e_wen;
    logic [31:0] e_opa, e_opb, e_busy;
  } vec_t;

  function automatic vec_t mk(input logic iv, input logic [5:0] opc, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [15:0] imm, input logic wbv,
                              input logic [4:0] wbr, input logic fl, input logic ordy,
                              input logic e_rdy, input logic e_vld, input logic [4:0] e_dest,
                              input logic e_wen, input logic [31:0] e_opa, input logic [31:0] e_opb,
                              input logic [31:0] e_busy);
    vec_t v;
    v.iv = iv; v.opc = opc; v.rd = rd; v.rs1 = rs1; v.imm = imm;
    v.wbv = wbv; v.wbr = wbr; v.fl = fl; v.ordy = ordy;
    v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_dest = e_dest; v.e_wen = e_wen;
    v.e_opa = e_opa; v.e_opb = e_opb; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic do_reset();
    clear_n = 1'b0; in_valid = 1'b1; wb_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_opcode", {26'd0, out_opcode}, 32'd0);
    chk("rst_dest_wen", {26'd0, out_dest, out_wen}, 32'd0);
    chk("rst_opA", out_opA, 32'd0);
    chk("rst_opB", out_opB, 32'd0);
    @(negedge clk);
    clear_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic apply_vec(input int idx, input vec_t v);
    @(negedge clk);
    in_valid = v.iv; in_instr = {v.opc, v.rd, v.rs1, v.imm};
    wb_valid = v.wbv; wb_reg = v.wbr; flush = v.fl; out_ready = v.ordy;
    #1;
    chk($sformatf("vec%0d_in_ready", idx), {31'd0, in_ready}, {31'd0, v.e_rdy});
    @(posedge clk);
    #1;
    chk($sformatf("vec%0d_out_valid", idx), {31'd0, out_valid}, {31'd0, v.e_vld});
    chk($sformatf("vec%0d_busy", idx), busy_mask, v.e_busy);
    if (v.e_vld) begin
      chk($sformatf("vec%0d_dest_wen", idx), {26'd0, out_dest, out_wen}, {26'd0, v.e_dest, v.e_wen});
      chk($sformatf("vec%0d_opA", idx), out_opA, v.e_opa);
      chk($sformatf("vec%0d_opB", idx), out_opB, v.e_opb);
    end
  endtask

  // Reference model: scoreboard as a bit per register, buffer as one optional entry.
  bit          m_busy [32];
  bit          m_vld;
  logic [5:0]  m_opc;
  logic [4:0]  m_dest;
  bit          m_wen;
  logic [31:0] m_opa, m_opb;

  function automatic logic [31:0] m_busy_word();
    logic [31:0] w = '0;
    for (int i = 0; i < 32; i++) w[i] = m_busy[i];
    return w;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_vld = 1'b0;
  endtask

  task automatic rand_step(input int n);
    logic [5:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [15:0] imm;
    bit          iv, wbv, fl, ordy, writes, uses2, rdy, acc;
    logic [4:0]  wbr;
    opc  = 6'($urandom);
    rd   = 5'($urandom_range(0, 7));
    rs1  = 5'($urandom_range(0, 7));
    rs2  = 5'($urandom_range(0, 7));
    imm  = {rs2, 11'($urandom)};
    iv   = ($urandom_range(0, 3) != 0);
    wbv  = ($urandom_range(0, 9) < 4);
    wbr  = 5'($urandom_range(0, 7));
    fl   = ($urandom_range(0, 19) == 0);
    ordy = ($urandom_range(0, 9) < 7);
    writes = (opc < 6'd32);
    uses2  = ((opc % 32) < 16);
    @(negedge clk);
    in_valid = iv; in_instr = {opc, rd, rs1, imm};
    wb_valid = wbv; wb_reg = wbr; flush = fl; out_ready = ordy;
    #1;
    rdy = !fl && !(m_busy[rs1] || (uses2 && m_busy[rs2]) || (writes && m_busy[rd]))
          && (!m_vld || ordy);
    acc = iv && rdy;
    chk($sformatf("rnd%0d_in_ready", n), {31'd0, in_ready}, {31'd0, rdy});
    chk($sformatf("rnd%0d_rf_rd", n), {31'd0, rf_rd}, {31'd0, iv});
    chk($sformatf("rnd%0d_rf_addr", n), {22'd0, rf_read_regA, rf_read_regB}, {22'd0, rs1, rs2});
    if (wbv) m_busy[wbr] = 1'b0;
    if (fl && m_vld && m_wen) m_busy[m_dest] = 1'b0;
    if (acc && writes) m_busy[rd] = 1'b1;
    if (acc) begin
      m_vld = 1'b1; m_opc = opc; m_dest = rd; m_wen = writes; m_opa = rf[rs1];
      m_opb = uses2 ? rf[rs2] : 32'($signed(imm));
    end else if (fl || ordy) begin
      m_vld = 1'b0;
    end
    @(posedge clk);
    #1;
    chk($sformatf("rnd%0d_out_valid", n), {31'd0, out_valid}, {31'd0, m_vld});
    chk($sformatf("rnd%0d_busy", n), busy_mask, m_busy_word());
    if (m_vld) begin
      chk($sformatf("rnd%0d_hdr", n), {20'd0, out_opcode, out_dest, out_wen}, {20'd0, m_opc, m_dest, m_wen});
      chk($sformatf("rnd%0d_opA", n), out_opA, m_opa);
      chk($sformatf("rnd%0d_opB", n), out_opB, m_opb);
    end
  endtask

  vec_t vec [21];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 + 32'(i);
    rf[1] = 32'h123abc01;
    rf[2] = 32'haaaabcaa;

    //            iv opc   rd  rs1 imm       wbv wbr fl ordy  rdy vld dst wen opA           opB           busy
    vec[0]  = mk(1, 6'h01, 3,  1, 16'h1000, 0, 0, 0, 1,   1, 1, 3,  1, 32'h123abc01, 32'haaaabcaa, 32'h008);
    vec[1]  = mk(1, 6'h01, 4,  3, 16'h0000, 0, 0, 0, 1,   0, 0, 0,  0, 32'h0,        32'h0,        32'h008);
    vec[2]  = mk(1, 6'h01, 4,  3, 16'h0000, 1, 3, 0, 1,   0, 0, 0,  0, 32'h0,        32'h0,        32'h000);
    vec[3]  = mk(1, 6'h01, 4,  3, 16'h0000, 0, 0, 0, 1,   1, 1, 4,  1, 32'h10000003, 32'h10000000, 32'h010);
    vec[4]  = mk(1, 6'h11, 5,  0, 16'hFFF0, 0, 0, 0, 1,   1, 1, 5,  1, 32'h10000000, 32'hFFFFFFF0, 32'h030);
    vec[5]  = mk(1, 6'h21, 6,  1, 16'h1000, 0, 0, 0, 1,   1, 1, 6,  0, 32'h123abc01, 32'haaaabcaa, 32'h030);
    vec[6]  = mk(0, 6'h00, 0,  0, 16'h0000, 1, 4, 0, 1,   1, 0, 0,  0, 32'h0,        32'h0,        32'h020);
    vec[7]  = mk(0, 6'h00, 0,  0, 16'h0000, 1, 5, 0, 1,   1, 0, 0,  0, 32'h0,        32'h0,        32'h000);
    vec[8]  = mk(1, 6'h01, 8,  1, 16'h1000, 0, 0, 0, 0,   1, 1, 8,  1, 32'h123abc01, 32'haaaabcaa, 32'h100);
    for (int i = 9; i <= 12; i++)
      vec[i] = mk(1, 6'h01, 10, 1, 16'h1000, 0, 0, 0, 0,  0, 1, 8,  1, 32'h123abc01, 32'haaaabcaa, 32'h100);
    vec[13] = mk(1, 6'h01, 10, 1, 16'h1000, 0, 0, 0, 1,   1, 1, 10, 1, 32'h123abc01, 32'haaaabcaa, 32'h500);
    vec[14] = mk(1, 6'h01, 7,  0, 16'h0000, 1, 7, 0, 1,   1, 1, 7,  1, 32'h10000000, 32'h10000000, 32'h580);
    vec[15] = mk(1, 6'h01, 7,  1, 16'h1000, 0, 0, 0, 1,   0, 0, 0,  0, 32'h0,        32'h0,        32'h580);
    vec[16] = mk(1, 6'h01, 9,  0, 16'h0000, 0, 0, 0, 0,   1, 1, 9,  1, 32'h10000000, 32'h10000000, 32'h780);
    vec[17] = mk(1, 6'h01, 11, 0, 16'h0000, 0, 0, 1, 0,   0, 0, 0,  0, 32'h0,        32'h0,        32'h580);
    vec[18] = mk(1, 6'h01, 9,  0, 16'h0000, 0, 0, 0, 0,   1, 1, 9,  1, 32'h10000000, 32'h10000000, 32'h780);
    vec[19] = mk(0, 6'h00, 0,  0, 16'h0000, 1, 8, 1, 0,   0, 0, 0,  0, 32'h0,        32'h0,        32'h480);
    vec[20] = mk(1, 6'h01, 12, 0, 16'h0000, 0, 0, 1, 0,   0, 0, 0,  0, 32'h0,        32'h0,        32'h480);

    do_reset();
    for (int i = 0; i < 21; i++) apply_vec(i, vec[i]);

    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    do_reset();
    m_clear();
    for (int n = 0; n < 2000; n++) begin
      rand_step(n);
      if (n == 1000) begin
        // Reset mid-traffic must drop buffer and scoreboard without waiting for a clock edge.
        @(negedge clk);
        #2;
        clear_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("async_rst_busy", busy_mask, 32'd0);
        chk("async_rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clear_n = 1'b1;
        m_clear();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
